// File: rtl/verbus_arbiter.sv
// verbus_arbiter: two-master round-robin Verbus arbiter with one-transaction grants and slave timeout
module verbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_wstrobe,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_wstrobe,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_address,
  output logic [3:0]  s_wstrobe,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        timeout_err,
  input  logic        timeout_clear
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;
  localparam int CW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic TO_EN = TIMEOUT_CYCLES != 0;

  logic [1:0]    state, state_next;
  logic          last, last_next;
  logic [CW-1:0] count, count_next;
  logic          g0, g1, gv, done, tmo, abort;

  // Decode the grant and classify how the current granted cycle ends
  always_comb begin
    g0 = state == GRANT0;
    g1 = state == GRANT1;
    gv = (g0 & m0_valid) | (g1 & m1_valid);
    done = gv & s_ready;
    tmo = gv & ~s_ready & TO_EN & (count == LIMIT);
    abort = (state != IDLE) & ~gv;
  end

  // Outputs are gated by reset so an abandoned request drops without waiting for a clock
  assign s_valid   = reset & gv;
  assign m0_ready  = reset & g0 & (done | tmo);
  assign m1_ready  = reset & g1 & (done | tmo);
  assign m0_rdata  = (g0 & tmo) ? '0 : s_rdata;
  assign m1_rdata  = (g1 & tmo) ? '0 : s_rdata;
  assign s_address = g1 ? m1_address : m0_address;
  assign s_wstrobe = g1 ? m1_wstrobe : m0_wstrobe;
  assign s_wdata   = g1 ? m1_wdata : m0_wdata;

  // Arbitration, completion, abort and timeout counting
  always_comb begin
    state_next = state;
    last_next = last;
    count_next = '0;
    if (state == IDLE)
      state_next = (m0_valid & m1_valid) ? (last ? GRANT0 : GRANT1) :
                   m0_valid ? GRANT0 : m1_valid ? GRANT1 : IDLE;
    else if (abort)
      state_next = IDLE;
    else if (done | tmo) begin
      state_next = IDLE;
      last_next = g1;
    end else
      count_next = count + 1'b1;
  end

  // State registers; a timeout set takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      last <= last_next;
      count <= count_next;
      timeout_err <= tmo ? 1'b1 : timeout_clear ? 1'b0 : timeout_err;
    end
  end
endmodule

// File: tb/tb_verbus_arbiter.sv
// tb_verbus_arbiter: directed and randomized checks of verbus_arbiter against a transaction-level model
module tb_verbus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_address = '0, m1_address = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrobe = '0, m1_wstrobe = '0;
  logic [31:0] m0_rdata, m1_rdata, s_address, s_wdata;
  logic        m0_ready, m1_ready, s_valid, timeout_err;
  logic [3:0]  s_wstrobe;
  logic [31:0] s_rdata = '0;
  logic        s_ready = 1'b0, timeout_clear = 1'b0;

  verbus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .timeout_err(timeout_err), .timeout_clear(timeout_clear)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: who owns the bus, which granted cycle this is, who went last
  int owner = -1, last_m = 1, waited = 0, own, nth;
  bit te = 1'b0, gv, tmo, fin, exp_r0 = 1'b0, exp_r1 = 1'b0;

  always @(negedge clk) begin
    own = reset ? owner : -1;
    gv = (own == 0 && m0_valid) || (own == 1 && m1_valid);
    nth = waited + 1;
    tmo = gv && !s_ready && TO != 0 && nth == TO + 1;
    fin = gv && (s_ready || tmo);
    exp_r0 = own == 0 && fin;
    exp_r1 = own == 1 && fin;
    chk("s_valid", 32'(s_valid), 32'(gv));
    chk("s_address", s_address, own == 1 ? m1_address : m0_address);
    chk("s_wstrobe", 32'(s_wstrobe), 32'(own == 1 ? m1_wstrobe : m0_wstrobe));
    chk("s_wdata", s_wdata, own == 1 ? m1_wdata : m0_wdata);
    chk("m0_ready", 32'(m0_ready), 32'(exp_r0));
    chk("m1_ready", 32'(m1_ready), 32'(exp_r1));
    chk("m0_rdata", m0_rdata, (own == 0 && tmo) ? 32'h0 : s_rdata);
    chk("m1_rdata", m1_rdata, (own == 1 && tmo) ? 32'h0 : s_rdata);
    chk("timeout_err", 32'(timeout_err), 32'(reset ? te : 1'b0));
    if (!reset) begin
      owner = -1; last_m = 1; waited = 0; te = 1'b0;
    end else begin
      if (own < 0) begin
        owner = (m0_valid && m1_valid) ? (last_m == 0 ? 1 : 0) : m0_valid ? 0 : m1_valid ? 1 : -1;
        waited = 0;
      end else if (!gv) owner = -1;
      else if (fin) begin
        last_m = own; owner = -1;
      end else waited = nth;
      te = tmo ? 1'b1 : timeout_clear ? 1'b0 : te;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input bit rdy, inout logic v, inout logic [31:0] a, inout logic [3:0] ws,
                         inout logic [31:0] wd);
    if (v && !rdy) begin
      if ($urandom_range(0, 49) == 0) v = 1'b0;
    end else begin
      v = 1'($urandom_range(0, 1));
      a = $urandom;
      ws = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      wd = $urandom;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // single master read
    reset = 1'b1; m0_valid = 1'b1; m0_address = 32'h10; m0_wstrobe = 4'h0;
    @(negedge clk); chk("t1_idle_svalid", 32'(s_valid), 32'h0);
    cyc(); s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_svalid", 32'(s_valid), 32'h1);
    chk("t1_m0_ready", 32'(m0_ready), 32'h1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_ready", 32'(m1_ready), 32'h0);
    cyc(); m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk); chk("t1_m0_ready_after", 32'(m0_ready), 32'h0);
    // tie right after reset
    cyc(); reset = 1'b0;
    @(negedge clk);
    cyc(); reset = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1; m0_address = 32'hA0; m1_address = 32'hA1;
    @(negedge clk); chk("t2_idle_svalid", 32'(s_valid), 32'h0);
    cyc(); s_ready = 1'b1;
    @(negedge clk);
    chk("t2_first_addr", s_address, 32'hA0);
    chk("t2_first_m0_ready", 32'(m0_ready), 32'h1);
    chk("t2_first_m1_ready", 32'(m1_ready), 32'h0);
    cyc(); m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk); chk("t2_gap_svalid", 32'(s_valid), 32'h0);
    cyc(); s_ready = 1'b1;
    @(negedge clk);
    chk("t2_second_addr", s_address, 32'hA1);
    chk("t2_second_m1_ready", 32'(m1_ready), 32'h1);
    cyc(); m1_valid = 1'b0; s_ready = 1'b0;
    // sustained contention with a one-wait slave
    for (int k = 0; k < 6; k++) begin
      m0_valid = 1'b1; m1_valid = 1'b1;
      m0_wdata = 32'h1000_0000 + k; m1_wdata = 32'h2000_0000 + k;
      m0_wstrobe = 4'hC; m1_wstrobe = 4'h3;
      @(negedge clk); chk("t3_idle_svalid", 32'(s_valid), 32'h0);
      cyc();
      @(negedge clk);
      chk("t3_svalid", 32'(s_valid), 32'h1);
      chk("t3_wdata", s_wdata, ((k % 2) == 1 ? 32'h2000_0000 : 32'h1000_0000) + k);
      chk("t3_wstrobe", 32'(s_wstrobe), (k % 2) == 1 ? 32'h3 : 32'hC);
      cyc(); s_ready = 1'b1;
      @(negedge clk);
      chk("t3_m0_ready", 32'(m0_ready), 32'((k % 2) == 0));
      chk("t3_m1_ready", 32'(m1_ready), 32'((k % 2) == 1));
      cyc(); s_ready = 1'b0;
    end
    // timeout on a stalled write
    m0_valid = 1'b0; m1_valid = 1'b1; m1_wstrobe = 4'hF; m1_wdata = 32'hCAFE0001; s_rdata = 32'h12345678;
    @(negedge clk); chk("t4_idle_svalid", 32'(s_valid), 32'h0);
    for (int g = 1; g <= 5; g++) begin
      cyc();
      @(negedge clk);
      if (g < 5) chk("t4_wait_m1_ready", 32'(m1_ready), 32'h0);
      else begin
        chk("t4_m1_ready", 32'(m1_ready), 32'h1);
        chk("t4_m1_rdata", m1_rdata, 32'h0);
        chk("t4_m0_rdata", m0_rdata, 32'h12345678);
        chk("t4_wstrobe", 32'(s_wstrobe), 32'hF);
      end
    end
    cyc(); m1_valid = 1'b0; timeout_clear = 1'b1;
    @(negedge clk); chk("t4_err_set", 32'(timeout_err), 32'h1);
    cyc(); timeout_clear = 1'b0;
    @(negedge clk); chk("t4_err_cleared", 32'(timeout_err), 32'h0);
    // reset while granted to a stalled slave
    cyc(); m0_valid = 1'b1; m0_address = 32'h44;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("t5_granted", 32'(s_valid), 32'h1);
    #2 s_ready = 1'b1; reset = 1'b0;
    #1;
    chk("t5_rst_svalid", 32'(s_valid), 32'h0);
    chk("t5_rst_m0_ready", 32'(m0_ready), 32'h0);
    chk("t5_rst_m1_ready", 32'(m1_ready), 32'h0);
    cyc(); s_ready = 1'b0; m1_valid = 1'b1;
    @(negedge clk);
    cyc(); reset = 1'b1;
    @(negedge clk); chk("t5_idle_svalid", 32'(s_valid), 32'h0);
    cyc(); s_ready = 1'b1;
    @(negedge clk);
    chk("t5_addr", s_address, 32'h44);
    chk("t5_m0_ready", 32'(m0_ready), 32'h1);
    chk("t5_m1_ready", 32'(m1_ready), 32'h0);
    cyc(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    // stray ready in idle
    @(negedge clk);
    cyc(); s_ready = 1'b1;
    @(negedge clk);
    chk("t6_m0_ready", 32'(m0_ready), 32'h0);
    chk("t6_m1_ready", 32'(m1_ready), 32'h0);
    chk("t6_svalid", 32'(s_valid), 32'h0);
    cyc(); s_ready = 1'b0; m1_valid = 1'b1; m1_address = 32'h77;
    @(negedge clk); chk("t6_still_idle", 32'(s_valid), 32'h0);
    cyc(); s_ready = 1'b1;
    @(negedge clk);
    chk("t6_addr", s_address, 32'h77);
    chk("t6_m1_ready", 32'(m1_ready), 32'h1);
    cyc(); m1_valid = 1'b0; s_ready = 1'b0;
    // randomized traffic, with a slow-slave phase to provoke timeouts
    for (int i = 0; i < 1500; i++) begin
      cyc();
      drive_m(exp_r0, m0_valid, m0_address, m0_wstrobe, m0_wdata);
      drive_m(exp_r1, m1_valid, m1_address, m1_wstrobe, m1_wdata);
      s_ready = $urandom_range(0, 99) < (i < 600 ? 50 : i < 1000 ? 3 : 30);
      s_rdata = $urandom;
      timeout_clear = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 299) != 0;
    end
    cyc(); reset = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
